// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single shared memory port.
// Ties go to DM by default; define ARB_RR_EN to alternate ties between the two ports.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic          if_we,
  input  logic [AW-1:0] if_addr,
  input  logic [DW-1:0] if_wdata,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic          owner_dm;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [7:0]    tmo_cnt;
  logic          grant;
  logic          pick_dm;
  logic          timeout;

  // Gated by reset so no grant pulse can escape while the block is held in reset.
  assign grant   = reset && (state == IDLE) && (if_req || dm_req);
  assign timeout = (state == ACCESS) && !mem_ready && (tmo_cnt == 8'(TMO - 1));

`ifdef ARB_RR_EN
  logic last_dm;

  // The port that did not win last time takes a tie.
  assign pick_dm = dm_req && (!if_req || !last_dm);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     last_dm <= 1'b0;
    else if (grant) last_dm <= pick_dm;
  end
`else
  assign pick_dm = dm_req;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || dm_req) state_nxt = ACCESS;
      ACCESS: begin
        if (mem_ready)    state_nxt = RESP;
        else if (timeout) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the datapath latches are reset too, so a dropped transaction leaves no residue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_dm  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      owner_dm  <= pick_dm;
      lat_we    <= pick_dm ? dm_we    : if_we;
      lat_addr  <= pick_dm ? dm_addr  : if_addr;
      lat_wdata <= pick_dm ? dm_wdata : if_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            rdata <= '0;
    else if (state == ACCESS && mem_ready) rdata <= mem_rdata;
  end

  // Counts stalled ACCESS cycles; cleared whenever the access is not stalling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             tmo_cnt <= '0;
    else if (state == ACCESS && !mem_ready) tmo_cnt <= timeout ? 8'd0 : tmo_cnt + 8'd1;
    else                                    tmo_cnt <= '0;
  end

  assign if_gnt    = grant && !pick_dm;
  assign dm_gnt    = grant && pick_dm;
  assign mem_req   = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign if_rvalid = (state == RESP) && !owner_dm;
  assign dm_rvalid = (state == RESP) && owner_dm;
  assign busy      = (state != IDLE);
  assign err       = timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: transactions are predicted at issue time,
// a monitor pops them on grant and checks the access, the response and the error pulse.
module tb_mem_arbiter;

  localparam int TMO = 4;

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    bit          tmo;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_we = 1'b0;
  logic [31:0] if_addr = '0, if_wdata = '0;
  logic        if_gnt, if_rvalid;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        busy, err;

  int checks = 0;
  int failures = 0;

  txn_t        exp_q[$];
  int          lat_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] rsp_mem[16];
  bit          last_was_dm = 1'b0;

  mem_arbiter #(.AW(32), .DW(32), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_wdata(if_wdata),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit tie_dm();
`ifdef ARB_RR_EN
    return !last_was_dm;
`else
    return 1'b1;
`endif
  endfunction

  function automatic txn_t rand_txn(input bit dm);
    txn_t t;
    t.dm    = dm;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.lat   = ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
    t.rdata = '0;
    t.tmo   = 1'b0;
    return t;
  endfunction

  // Called in grant order: memory effect, expected read data and timeout outcome.
  function automatic void predict(input txn_t t);
    t.tmo   = (t.lat >= TMO);
    t.rdata = ref_mem[t.addr[3:0]];
    if (t.we && !t.tmo) ref_mem[t.addr[3:0]] = t.wdata;
    last_was_dm = t.dm;
    exp_q.push_back(t);
    lat_q.push_back(t.lat);
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int rcnt = 0;
    int rlat = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (rcnt == 0) rlat = (lat_q.size() > 0) ? lat_q.pop_front() : 1000;
        if (rcnt == rlat) begin
          mem_ready = 1'b1;
          mem_rdata = rsp_mem[mem_addr[3:0]];
          if (mem_we) rsp_mem[mem_addr[3:0]] = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        rcnt++;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        rcnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  txn_t        cur;
  bit          in_txn = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] last_rdata = '0;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_pulses", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, busy, err}, 0);
      check("rst_data", {rdata, mem_addr, mem_wdata}, 0);
      in_txn = 1'b0;
      last_rdata = '0;
    end else begin
      check("busy", busy, in_txn);
      if (if_gnt || dm_gnt) begin
        check("gnt_while_busy", in_txn, 0);
        check("gnt_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("gnt_port", {if_gnt, dm_gnt}, cur.dm ? 2'b01 : 2'b10);
        end
        in_txn = 1'b1;
        acc_cnt = 0;
      end else if (!in_txn) begin
        check("idle_quiet", {if_rvalid, dm_rvalid, mem_req, mem_we, err}, 0);
      end else if (if_rvalid || dm_rvalid) begin
        check("rvalid_port", {if_rvalid, dm_rvalid}, cur.dm ? 2'b01 : 2'b10);
        check("rvalid_no_mem_req", mem_req, 0);
        check("rvalid_not_timeout", cur.tmo, 0);
        check("rvalid_latency", acc_cnt, cur.lat + 1);
        check("rdata", rdata, cur.rdata);
        last_rdata = cur.rdata;
        in_txn = 1'b0;
      end else begin
        check("mem_req", mem_req, 1);
        check("mem_we", mem_we, cur.we);
        check("mem_addr", mem_addr, cur.addr);
        check("mem_wdata", mem_wdata, cur.wdata);
        acc_cnt++;
        if (err) begin
          check("err_expected", cur.tmo, 1);
          check("err_latency", acc_cnt, TMO);
          check("err_rdata_kept", rdata, last_rdata);
          in_txn = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_if(input txn_t t);
    if_we = t.we; if_addr = t.addr; if_wdata = t.wdata;
  endtask

  task automatic drive_dm(input txn_t t);
    dm_we = t.we; dm_addr = t.addr; dm_wdata = t.wdata;
  endtask

  task automatic wait_grant(output bit g, output bit ok);
    ok = 1'b0;
    g  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        ok = 1'b1;
        g  = dm_gnt;
        break;
      end
    end
    check("grant_wait", ok, 1);
  endtask

  // Raise the chosen requests together; each is dropped (payload scrambled) once granted.
  task automatic run_round(input bit r_if, input bit r_dm, input txn_t ti, input txn_t td);
    bit g, ok;
    int n;
    @(posedge clk);
    #1;
    if (r_if) begin drive_if(ti); if_req = 1'b1; end
    if (r_dm) begin drive_dm(td); dm_req = 1'b1; end
    if (r_if && r_dm) begin
      if (tie_dm()) begin predict(td); predict(ti); end
      else          begin predict(ti); predict(td); end
    end else if (r_if) predict(ti);
    else if (r_dm)     predict(td);
    n = int'(r_if) + int'(r_dm);
    for (int i = 0; i < n; i++) begin
      wait_grant(g, ok);
      if (!ok) break;
      @(posedge clk);
      #1;
      if (g) begin dm_req = 1'b0; drive_dm(rand_txn(1)); end
      else   begin if_req = 1'b0; drive_if(rand_txn(0)); end
    end
  endtask

  // Both requests stay high across four grants; the winner re-arms with a new payload.
  task automatic hold_both();
    txn_t ti, td;
    bit w, g, ok;
    ti = rand_txn(0);
    td = rand_txn(1);
    @(posedge clk);
    #1;
    drive_if(ti); drive_dm(td);
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = tie_dm();
      predict(w ? td : ti);
      wait_grant(g, ok);
      if (!ok) break;
      @(posedge clk);
      #1;
      if (i == 3) begin if_req = 1'b0; dm_req = 1'b0; end
      else if (w) begin td = rand_txn(1); drive_dm(td); end
      else        begin ti = rand_txn(0); drive_if(ti); end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  initial begin
    txn_t t, d;
    bit g, ok;
    int mode;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h5A00_0000 + 32'(i * 32'h0101_0101);
      rsp_mem[i] = 32'h5A00_0000 + 32'(i * 32'h0101_0101);
    end
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    hold_both();

    // Write a known word, then fetch it back with a zero-wait memory.
    d = rand_txn(0);
    t = rand_txn(1);
    t.we = 1'b1; t.addr = 32'h0000_0105; t.wdata = 32'h8C22_0004; t.lat = 1;
    run_round(0, 1, d, t);
    t = rand_txn(0);
    t.we = 1'b0; t.addr = 32'h0000_0105; t.lat = 0;
    run_round(1, 0, t, d);

    // Data write with three wait states.
    t = rand_txn(1);
    t.we = 1'b1; t.addr = 32'h0000_0010; t.wdata = 32'hDEAD_BEEF; t.lat = 3;
    run_round(0, 1, d, t);

    // Memory never ready: timeout abort.
    t = rand_txn(0);
    t.we = 1'b0; t.lat = TMO;
    run_round(1, 0, t, d);

    for (int r = 0; r < 60; r++) begin
      mode = int'($urandom_range(1, 3));
      run_round(mode[0], mode[1], rand_txn(0), rand_txn(1));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    // Reset in the middle of a stalled access.
    t = rand_txn(1);
    t.we = 1'b0; t.lat = 1000;
    @(posedge clk);
    #1;
    drive_dm(t); dm_req = 1'b1;
    predict(t);
    wait_grant(g, ok);
    @(posedge clk);
    #1 dm_req = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_mem_req", mem_req, 0);
    check("rst_async_busy", busy, 0);
    last_was_dm = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);

    // First tie after reset goes to DM under either policy.
    run_round(1, 1, rand_txn(0), rand_txn(1));

    for (int i = 0; i < 200 && (exp_q.size() != 0 || in_txn); i++) @(negedge clk);
    check("drain", {exp_q.size() == 0, in_txn}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
